// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the shared-RAM memory arbiter.
//   arb_mode_e : arbitration policy selector (fixed priority / round-robin)
//   MAX_CH     : largest supported number of requester channels
//   ch_id_w()  : width of a channel index, never less than one bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int MAX_CH = 8;

    function automatic int ch_id_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// ---------------------------------------------------------------------------
// arb_rr_picker
// Combinational find-first over a request vector, starting at i_start and
// searching upward with wrap-around. Driving i_start with zero gives plain
// lowest-index-wins priority.
//   i_req   : request vector, one bit per channel
//   i_start : index searched first
//   o_gnt   : one-hot winner, zero when nothing requests
//   o_id    : binary index of the winner (zero when nothing requests)
//   o_any   : at least one channel is requesting
// ---------------------------------------------------------------------------
module arb_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]              i_req,
    input  logic [ch_id_w(NUM_CH)-1:0]     i_start,
    output logic [NUM_CH-1:0]              o_gnt,
    output logic [ch_id_w(NUM_CH)-1:0]     o_id,
    output logic                           o_any
);

    localparam int IDW = ch_id_w(NUM_CH);

    // Two passes instead of a rotate: the first only considers channels at
    // or above the start index; if none of those request, the second pass
    // finds the lowest requester, which is necessarily below the start.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_start))) begin
                o_gnt[j] = 1'b1;
                o_id     = IDW'(j);
                o_any    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!o_any && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_id     = IDW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
// N-channel arbiter in front of a single shared RAM port. One access is
// issued per cycle; reads return RD_LAT cycles later and are steered back to
// their requester by a tag pipeline. A channel can lock the port for atomic
// sequences, during which only it may be granted.
//
// Ports
//   clk        : clock
//   rst        : asynchronous, active-low reset
//   req        : per-channel access request
//   we         : per-channel byte write enables (zero = read)
//   lock       : per-channel "keep exclusive ownership after this access"
//   addr/wdata : per-channel address and write data
//   gnt        : one-hot grant, combinational in the request cycle
//   stall      : req & ~gnt
//   rvalid     : one-hot read return strobe
//   rdata      : read return data (pass-through of ram_rdata)
//   ram_addr/ram_wdata/ram_we/ram_re : RAM port, driven by the granted channel
//   ram_rdata  : RAM read data, RD_LAT cycles after ram_re
// ---------------------------------------------------------------------------
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int        NUM_CH   = 2,
    parameter int        ADDR_W   = 32,
    parameter int        DATA_W   = 32,
    parameter int        RD_LAT   = 1,
    parameter arb_mode_e ARB_MODE = ARB_RR
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  req,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0]    we,
    input  logic [NUM_CH-1:0]                  lock,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]      addr,
    input  logic [NUM_CH-1:0][DATA_W-1:0]      wdata,
    output logic [NUM_CH-1:0]                  gnt,
    output logic [NUM_CH-1:0]                  stall,
    output logic [NUM_CH-1:0]                  rvalid,
    output logic [DATA_W-1:0]                  rdata,
    output logic [ADDR_W-1:0]                  ram_addr,
    output logic [DATA_W-1:0]                  ram_wdata,
    output logic [DATA_W/8-1:0]                ram_we,
    output logic                               ram_re,
    input  logic [DATA_W-1:0]                  ram_rdata
);

    localparam int IDW  = ch_id_w(NUM_CH);
    localparam int BE_W = DATA_W / 8;

    // Arbitration / lock state
    logic [IDW-1:0]              r_ptr;
    logic                        r_locked;
    logic [IDW-1:0]              r_owner;

    // Read tag pipeline: valid bits are control (reset), ids are payload
    logic [RD_LAT-1:0]           r_tag_vld;
    logic [RD_LAT-1:0][IDW-1:0]  r_tag_id;

    logic [NUM_CH-1:0]           w_owner_mask;
    logic                        w_owner_lock;
    logic [NUM_CH-1:0]           w_req_elig;
    logic [IDW-1:0]              w_start;
    logic [NUM_CH-1:0]           w_gnt;
    logic [IDW-1:0]              w_gnt_id;
    logic                        w_any;
    logic [ADDR_W-1:0]           w_addr_sel;
    logic [DATA_W-1:0]           w_wdata_sel;
    logic [BE_W-1:0]             w_we_sel;
    logic                        w_lock_sel;

    // ---------------------------------------------------------------------
    // Eligibility: nothing is granted while reset is held; while locked,
    // only the owner may compete, even when the owner is idle.
    // ---------------------------------------------------------------------
    always_comb begin
        w_owner_mask = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_owner_mask[j] = (r_owner == IDW'(j));
        end
    end

    assign w_owner_lock = |(lock & w_owner_mask);

    always_comb begin
        w_req_elig = '0;
        if (rst) begin
            w_req_elig = r_locked ? (req & w_owner_mask) : req;
        end
    end

    assign w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

    arb_rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .i_req   (w_req_elig),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    assign gnt   = w_gnt;
    assign stall = req & ~w_gnt;

    // ---------------------------------------------------------------------
    // Issue mux: the picker reports id 0 when idle, so with no grant the
    // RAM address/data simply follow channel 0.
    // ---------------------------------------------------------------------
    always_comb begin
        w_addr_sel  = addr[0];
        w_wdata_sel = wdata[0];
        w_we_sel    = we[0];
        w_lock_sel  = lock[0];
        for (int j = 1; j < NUM_CH; j++) begin
            if (w_gnt_id == IDW'(j)) begin
                w_addr_sel  = addr[j];
                w_wdata_sel = wdata[j];
                w_we_sel    = we[j];
                w_lock_sel  = lock[j];
            end
        end
    end

    assign ram_addr  = w_addr_sel;
    assign ram_wdata = w_wdata_sel;
    assign ram_we    = w_any ? w_we_sel : '0;
    assign ram_re    = w_any & ~(|w_we_sel);

    // ---------------------------------------------------------------------
    // Pointer and lock state, updated at the edge ending the cycle.
    // A grant always rewrites the lock from the winner's lock bit; without a
    // grant the owner can still release by dropping its lock bit.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_any) begin
            r_ptr    <= (w_gnt_id == IDW'(NUM_CH - 1)) ? '0 : (w_gnt_id + 1'b1);
            r_locked <= w_lock_sel;
            r_owner  <= w_gnt_id;
        end else begin
            r_locked <= r_locked & w_owner_lock;
        end
    end

    // ---------------------------------------------------------------------
    // Tag pipeline stage boundary: stage 0 captures this cycle's read, every
    // stage shifts each edge; reset wipes in-flight valids so aborted reads
    // never return.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= ram_re;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int s = 1; s < RD_LAT; s++) begin
            r_tag_id[s] <= r_tag_id[s-1];
        end
    end

    // ---------------------------------------------------------------------
    // Read return: tail of the tag pipeline selects the receiving channel.
    // ---------------------------------------------------------------------
    always_comb begin
        rvalid = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            rvalid[j] = r_tag_vld[RD_LAT-1] && (r_tag_id[RD_LAT-1] == IDW'(j));
        end
    end

    assign rdata = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rr
// Three arbiter configurations sharing one clock and reset:
//   A : 2 channels, round-robin, RD_LAT=1
//   B : 3 channels, fixed priority, RD_LAT=2
//   C : 4 channels, round-robin, RD_LAT=3
// Each bench-side RAM returns a fixed function of the address after the
// configured latency. Expected read returns are queued when a read is
// expected to be granted and popped whenever the DUT raises rvalid.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rr;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    function automatic logic [31:0] ramf(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5C3_0F0F;
    endfunction

    // ---------------- instance A ----------------
    logic [1:0]        a_req, a_lock, a_gnt, a_stall, a_rvalid;
    logic [1:0][3:0]   a_we;
    logic [1:0][31:0]  a_addr, a_wdata;
    logic [31:0]       a_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic [3:0]        a_ram_we;
    logic              a_ram_re;
    logic [31:0]       a_q0;

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .ARB_MODE(ARB_RR)) u_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .lock(a_lock), .addr(a_addr),
        .wdata(a_wdata), .gnt(a_gnt), .stall(a_stall), .rvalid(a_rvalid), .rdata(a_rdata),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we), .ram_re(a_ram_re),
        .ram_rdata(a_ram_rdata));

    always @(posedge clk) a_q0 <= ramf(a_ram_addr);
    assign a_ram_rdata = a_q0;

    // ---------------- instance B ----------------
    logic [2:0]        b_req, b_lock, b_gnt, b_stall, b_rvalid;
    logic [2:0][3:0]   b_we;
    logic [2:0][31:0]  b_addr, b_wdata;
    logic [31:0]       b_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [3:0]        b_ram_we;
    logic              b_ram_re;
    logic [31:0]       b_q0, b_q1;

    mem_arbiter_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RD_LAT(2), .ARB_MODE(ARB_FIXED)) u_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .lock(b_lock), .addr(b_addr),
        .wdata(b_wdata), .gnt(b_gnt), .stall(b_stall), .rvalid(b_rvalid), .rdata(b_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_re(b_ram_re),
        .ram_rdata(b_ram_rdata));

    always @(posedge clk) begin
        b_q0 <= ramf(b_ram_addr);
        b_q1 <= b_q0;
    end
    assign b_ram_rdata = b_q1;

    // ---------------- instance C ----------------
    logic [3:0]        c_req, c_lock, c_gnt, c_stall, c_rvalid;
    logic [3:0][3:0]   c_we;
    logic [3:0][31:0]  c_addr, c_wdata;
    logic [31:0]       c_rdata, c_ram_addr, c_ram_wdata, c_ram_rdata;
    logic [3:0]        c_ram_we;
    logic              c_ram_re;
    logic [31:0]       c_q0, c_q1, c_q2;

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(3), .ARB_MODE(ARB_RR)) u_c (
        .clk(clk), .rst(rst), .req(c_req), .we(c_we), .lock(c_lock), .addr(c_addr),
        .wdata(c_wdata), .gnt(c_gnt), .stall(c_stall), .rvalid(c_rvalid), .rdata(c_rdata),
        .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata), .ram_we(c_ram_we), .ram_re(c_ram_re),
        .ram_rdata(c_ram_rdata));

    always @(posedge clk) begin
        c_q0 <= ramf(c_ram_addr);
        c_q1 <= c_q0;
        c_q2 <= c_q1;
    end
    assign c_ram_rdata = c_q2;

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (a_rvalid !== 2'b00) begin
            n_chk++;
            if (qa.size() == 0) begin
                $display("FAIL a_rvalid_unexpected: rvalid=%b rdata=%h, required no return", a_rvalid, a_rdata);
            end else begin
                ea = qa.pop_front();
                if (a_rvalid !== 2'(1 << ea.ch) || a_rdata !== ea.d)
                    $display("FAIL a_read_return: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             a_rvalid, a_rdata, 2'(1 << ea.ch), ea.d);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (b_rvalid !== 3'b000) begin
            n_chk++;
            if (qb.size() == 0) begin
                $display("FAIL b_rvalid_unexpected: rvalid=%b rdata=%h, required no return", b_rvalid, b_rdata);
            end else begin
                eb = qb.pop_front();
                if (b_rvalid !== 3'(1 << eb.ch) || b_rdata !== eb.d)
                    $display("FAIL b_read_return: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             b_rvalid, b_rdata, 3'(1 << eb.ch), eb.d);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (c_rvalid !== 4'b0000) begin
            n_chk++;
            if (qc.size() == 0) begin
                $display("FAIL c_rvalid_unexpected: rvalid=%b rdata=%h, required no return", c_rvalid, c_rdata);
            end else begin
                ec = qc.pop_front();
                if (c_rvalid !== 4'(1 << ec.ch) || c_rdata !== ec.d)
                    $display("FAIL c_read_return: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             c_rvalid, c_rdata, 4'(1 << ec.ch), ec.d);
                else n_pass++;
            end
        end
    end

    // ---------------- helpers (timing only) ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_req = '0; a_lock = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_lock = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        c_req = '0; c_lock = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12 && (qa.size() + qb.size() + qc.size()) != 0; i++) nxt();
        nxt();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        #3 rst = 1'b0;
        a_req = 2'b11;
        b_req = 3'b111;
        c_req = 4'b1111;
        c_we[2] = 4'hF;
        @(negedge clk);
        n_chk++;
        if (a_gnt !== 2'b00 || b_gnt !== 3'b000 || c_gnt !== 4'b0000)
            $display("FAIL reset_gnt: gnt a=%b b=%b c=%b, required all zero", a_gnt, b_gnt, c_gnt);
        else n_pass++;
        n_chk++;
        if (c_stall !== 4'b1111 || a_stall !== 2'b11)
            $display("FAIL reset_stall: stall a=%b c=%b, required a=11 c=1111", a_stall, c_stall);
        else n_pass++;
        n_chk++;
        if (c_ram_we !== 4'h0 || c_ram_re !== 1'b0 || a_ram_re !== 1'b0)
            $display("FAIL reset_ram: c_ram_we=%h c_ram_re=%b a_ram_re=%b, required 0 0 0",
                     c_ram_we, c_ram_re, a_ram_re);
        else n_pass++;
        n_chk++;
        if (a_rvalid !== 2'b00 || b_rvalid !== 3'b000 || c_rvalid !== 4'b0000)
            $display("FAIL reset_rvalid: rvalid a=%b b=%b c=%b, required all zero", a_rvalid, b_rvalid, c_rvalid);
        else n_pass++;
        nxt();
        rst = 1'b1;
        idle_all();
        nxt();
    endtask

    task automatic test_rr_alternate();
        logic [31:0] ex_addr;
        int          ex_ch;
        for (int k = 0; k < 8; k++) begin
            a_req     = 2'b11;
            a_we      = '0;
            a_addr[0] = 32'h1000 + k * 4;
            a_addr[1] = 32'h2000 + k * 4;
            ex_ch     = k % 2;
            ex_addr   = (ex_ch == 0) ? (32'h1000 + k * 4) : (32'h2000 + k * 4);
            @(negedge clk);
            n_chk++;
            if (a_gnt !== 2'(1 << ex_ch) || a_stall !== (2'b11 & ~2'(1 << ex_ch)) ||
                a_ram_addr !== ex_addr || a_ram_re !== 1'b1)
                $display("FAIL rr_alternate[%0d]: gnt=%b stall=%b ram_addr=%h ram_re=%b, required gnt=%b stall=%b ram_addr=%h ram_re=1",
                         k, a_gnt, a_stall, a_ram_addr, a_ram_re, 2'(1 << ex_ch), 2'b11 & ~2'(1 << ex_ch), ex_addr);
            else n_pass++;
            qa.push_back('{ch: ex_ch, d: ramf(ex_addr)});
            nxt();
        end
        idle_all();
        wait_idle();
        n_chk++;
        if (qa.size() != 0) $display("FAIL rr_alternate_drain: %0d returns pending, required 0", qa.size());
        else n_pass++;
    endtask

    task automatic test_fixed_prio();
        for (int k = 0; k < 6; k++) begin
            b_req  = 3'b111;
            b_lock = 3'b110;
            b_we   = '0;
            b_addr[0] = 32'h3000 + k * 4;
            b_addr[1] = 32'h3100 + k * 4;
            b_addr[2] = 32'h3200 + k * 4;
            @(negedge clk);
            n_chk++;
            if (b_gnt !== 3'b001 || b_stall !== 3'b110 || b_ram_addr !== (32'h3000 + k * 4))
                $display("FAIL fixed_prio[%0d]: gnt=%b stall=%b ram_addr=%h, required gnt=001 stall=110 ram_addr=%h",
                         k, b_gnt, b_stall, b_ram_addr, 32'h3000 + k * 4);
            else n_pass++;
            qb.push_back('{ch: 0, d: ramf(32'h3000 + k * 4)});
            nxt();
        end
        // Lock bits of never-granted channels must not have locked anyone out
        b_req     = 3'b010;
        b_lock    = 3'b000;
        b_addr[1] = 32'h3180;
        @(negedge clk);
        n_chk++;
        if (b_gnt !== 3'b010)
            $display("FAIL fixed_lock_ignored: gnt=%b, required 010", b_gnt);
        else n_pass++;
        qb.push_back('{ch: 1, d: ramf(32'h3180)});
        nxt();
        idle_all();
        wait_idle();
        n_chk++;
        if (qb.size() != 0) $display("FAIL fixed_prio_drain: %0d returns pending, required 0", qb.size());
        else n_pass++;
    endtask

    task automatic test_rd_lat3();
        logic [3:0] ex_rv;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                c_req     = 4'b0010;
                c_addr[1] = 32'h100 + k * 4;
            end else begin
                c_req = 4'b0000;
            end
            @(negedge clk);
            if (k < 3) begin
                n_chk++;
                if (c_gnt !== 4'b0010 || c_ram_addr !== (32'h100 + k * 4) || c_ram_re !== 1'b1)
                    $display("FAIL lat3_issue[%0d]: gnt=%b ram_addr=%h ram_re=%b, required gnt=0010 ram_addr=%h ram_re=1",
                             k, c_gnt, c_ram_addr, c_ram_re, 32'h100 + k * 4);
                else n_pass++;
                qc.push_back('{ch: 1, d: ramf(32'h100 + k * 4)});
            end
            ex_rv = (k >= 3 && k <= 5) ? 4'b0010 : 4'b0000;
            n_chk++;
            if (c_rvalid !== ex_rv)
                $display("FAIL lat3_timing[%0d]: rvalid=%b, required %b", k, c_rvalid, ex_rv);
            else n_pass++;
            nxt();
        end
        idle_all();
        wait_idle();
        n_chk++;
        if (qc.size() != 0) $display("FAIL lat3_drain: %0d returns pending, required 0", qc.size());
        else n_pass++;
    endtask

    task automatic test_lock();
        // ch0 alone first so the pointer moves to ch1
        c_req = 4'b0001; c_addr[0] = 32'h40;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0001) $display("FAIL lock_setup: gnt=%b, required 0001", c_gnt);
        else n_pass++;
        qc.push_back('{ch: 0, d: ramf(32'h40)});
        nxt();
        // ch1 locked read
        c_req = 4'b0011; c_lock = 4'b0010; c_addr[1] = 32'h200; c_we[1] = 4'h0;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0010 || c_stall !== 4'b0001)
            $display("FAIL lock_read: gnt=%b stall=%b, required gnt=0010 stall=0001", c_gnt, c_stall);
        else n_pass++;
        qc.push_back('{ch: 1, d: ramf(32'h200)});
        nxt();
        // owner idle but still holding lock
        c_req = 4'b0001; c_lock = 4'b0010;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0000 || c_stall !== 4'b0001)
            $display("FAIL lock_owner_idle: gnt=%b stall=%b, required gnt=0000 stall=0001", c_gnt, c_stall);
        else n_pass++;
        nxt();
        // owner writes and releases in the same access
        c_req = 4'b0011; c_lock = 4'b0000; c_we[1] = 4'hF; c_wdata[1] = 32'hDEADBEEF; c_addr[1] = 32'h204;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0010 || c_stall !== 4'b0001 || c_ram_we !== 4'hF || c_ram_re !== 1'b0 ||
            c_ram_wdata !== 32'hDEADBEEF || c_ram_addr !== 32'h204)
            $display("FAIL lock_write: gnt=%b stall=%b ram_we=%h ram_re=%b ram_wdata=%h ram_addr=%h, required 0010 0001 f 0 deadbeef 00000204",
                     c_gnt, c_stall, c_ram_we, c_ram_re, c_ram_wdata, c_ram_addr);
        else n_pass++;
        nxt();
        // ch0 wins the cycle after the release
        c_req = 4'b0001; c_we[1] = 4'h0;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0001 || c_stall !== 4'b0000)
            $display("FAIL lock_released: gnt=%b stall=%b, required gnt=0001 stall=0000", c_gnt, c_stall);
        else n_pass++;
        qc.push_back('{ch: 0, d: ramf(32'h40)});
        nxt();
        idle_all();
        wait_idle();
        n_chk++;
        if (qc.size() != 0) $display("FAIL lock_drain: %0d returns pending, required 0", qc.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        b_req = 3'b010; b_addr[1] = 32'h500;
        @(negedge clk);
        n_chk++;
        if (b_gnt !== 3'b010) $display("FAIL midrst_issue: gnt=%b, required 010", b_gnt);
        else n_pass++;
        nxt();
        rst   = 1'b0;
        b_req = 3'b000;
        @(negedge clk);
        n_chk++;
        if (b_gnt !== 3'b000 || b_rvalid !== 3'b000)
            $display("FAIL midrst_during: gnt=%b rvalid=%b, required 000 000", b_gnt, b_rvalid);
        else n_pass++;
        nxt();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (b_rvalid !== 3'b000) $display("FAIL midrst_no_return[%0d]: rvalid=%b, required 000", k, b_rvalid);
            else n_pass++;
            nxt();
        end
        b_req = 3'b100; b_addr[2] = 32'h600;
        @(negedge clk);
        n_chk++;
        if (b_gnt !== 3'b100 || b_ram_addr !== 32'h600 || b_ram_re !== 1'b1)
            $display("FAIL midrst_after: gnt=%b ram_addr=%h ram_re=%b, required 100 00000600 1", b_gnt, b_ram_addr, b_ram_re);
        else n_pass++;
        qb.push_back('{ch: 2, d: ramf(32'h600)});
        nxt();
        idle_all();
        wait_idle();
        n_chk++;
        if (qb.size() != 0) $display("FAIL midrst_drain: %0d returns pending, required 0", qb.size());
        else n_pass++;
    endtask

    task automatic test_rr_wrap();
        int ex_seq [3] = '{3, 1, 3};
        // pointer was cleared by the reset pulse: all four request, ch0 wins
        c_req = 4'b1111;
        c_addr[0] = 32'h700; c_addr[1] = 32'h710; c_addr[2] = 32'h720; c_addr[3] = 32'h730;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0001) $display("FAIL wrap_ptr_reset: gnt=%b, required 0001", c_gnt);
        else n_pass++;
        qc.push_back('{ch: 0, d: ramf(32'h700)});
        nxt();
        // single requester, pointer moves to 3
        c_req = 4'b0100;
        @(negedge clk);
        n_chk++;
        if (c_gnt !== 4'b0100) $display("FAIL wrap_single: gnt=%b, required 0100", c_gnt);
        else n_pass++;
        qc.push_back('{ch: 2, d: ramf(32'h720)});
        nxt();
        for (int k = 0; k < 3; k++) begin
            c_req = 4'b1010;
            c_addr[1] = 32'h810 + k * 4;
            c_addr[3] = 32'h830 + k * 4;
            @(negedge clk);
            n_chk++;
            if (c_gnt !== 4'(1 << ex_seq[k]))
                $display("FAIL wrap_seq[%0d]: gnt=%b, required %b", k, c_gnt, 4'(1 << ex_seq[k]));
            else n_pass++;
            qc.push_back('{ch: ex_seq[k],
                           d: ramf((ex_seq[k] == 1) ? (32'h810 + k * 4) : (32'h830 + k * 4))});
            nxt();
        end
        idle_all();
        wait_idle();
        n_chk++;
        if (qc.size() != 0) $display("FAIL wrap_drain: %0d returns pending, required 0", qc.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at 200000ns, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_alternate();
        test_fixed_prio();
        test_rd_lat3();
        test_lock();
        test_reset_mid_read();
        test_rr_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-channel memory arbiter between the CPU pipeline's memory ports (instruction fetch, data MEM stage, future DMA/MMIO masters) and a single shared RAM port. It supports:
- fixed-priority or round-robin arbitration;
- pipelined reads with a configurable RAM read latency, each routed back to its requester by a tag pipeline;
- a lock that gives one channel exclusive access for atomic (LL/SC, read-modify-write) sequences.

## Interface
Parameters:
- `NUM_CH`, 2: number of requester channels, 2..8; channel 0 is the instruction fetch port by convention.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8.
- `RD_LAT`, 1: RAM read latency in cycles, 1..4.
- `ARB_MODE`, `ARB_RR`: `ARB_FIXED` (lowest index wins) or `ARB_RR` (round-robin).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `req` in `NUM_CH`: per-channel access request.
- `we` in `NUM_CH` x `DATA_W/8`: byte write enables. Nonzero means write; zero means read.
- `lock` in `NUM_CH`: hold exclusive ownership after this access.
- `addr` in `NUM_CH` x `ADDR_W`: per-channel address.
- `wdata` in `NUM_CH` x `DATA_W`: per-channel write data.
- `gnt` out `NUM_CH`: one-hot or zero; the access is accepted this cycle.
- `stall` out `NUM_CH`: equals `req & ~gnt`; the pipeline holds.
- `rvalid` out `NUM_CH`: one-hot or zero; read data returns to that channel.
- `rdata` out `DATA_W`: shared read-return data.
- `ram_addr` out `ADDR_W`: RAM port address.
- `ram_wdata` out `DATA_W`: RAM port write data.
- `ram_we` out `DATA_W/8`: RAM port byte write enables.
- `ram_re` out 1: RAM port read enable.
- `ram_rdata` in `DATA_W`: RAM read data, valid `RD_LAT` cycles after `ram_re`.

## Operation
**Issue**
- At most one access is issued per cycle.
- The granted channel's `addr`, `wdata` and `we` drive the `ram_*` outputs combinationally.
- `ram_re` = `|gnt & (we[g]==0)`.
- With no grant: `ram_we`=0, `ram_re`=0, `ram_addr`/`ram_wdata` = channel 0 values (don't-care).

**Arbitration**
- `ARB_FIXED`: the lowest-index requesting channel wins.
- `ARB_RR`: the first requesting channel at or after pointer `ptr`, searching upward with wrap, wins.
- `ptr` updates to (granted+1) mod `NUM_CH` at the edge ending a grant cycle.
- `ptr` is unchanged when there is no grant.

**Lock**
- Registered state: `locked`, `owner`.
- While `locked`, only `owner` can be granted. Other channels stall even if `owner` is idle.
- On a grant to channel c at a clock edge: `locked` := `lock[c]`, `owner` := c.
- With no grant to the owner: `locked` := `locked & lock[owner]`. The owner dropping `lock` releases ownership without an access.
- `ptr` still advances on locked grants.

**Read return**
- A tag shift register of `RD_LAT` stages holds {valid, channel id}.
- Stage 0 loads {`ram_re`, granted id} each edge; every stage shifts every edge; there is no backpressure.
- `rvalid[id]` = tail valid; `rdata` = `ram_rdata` (combinational pass-through).
- Reads and writes interleave freely.
- Requesters accept `rvalid` unconditionally. A channel may have up to `RD_LAT` reads outstanding.

**Writes** produce no response; `gnt` is completion from the requester's view.

## Timing
- Grant is combinational: `gnt` is valid in the same cycle as `req` (cycle T).
- Read granted in T: `rvalid`/`rdata` appear in T+`RD_LAT`.
- Full throughput: one access per cycle. Reads are back-to-back in both fixed and round-robin modes.

**Reset** (`rst` low, asynchronous):
- `ptr`=0, `locked`=0, `owner`=0, all tag valids 0.
- `rvalid`=0.
- `gnt` is forced 0 while `rst` is low. Hence `ram_we`=0, `ram_re`=0 and `stall`=`req`.

**Boundaries**
- Reset mid-read: in-flight tags are cleared and no `rvalid` is ever issued for them.
- `ptr` wraps from `NUM_CH`-1 to 0.
- A single requester is granted every cycle regardless of `ptr`.
- `lock` asserted by a channel that is not granted has no effect.
- Simultaneous release (owner granted with `lock`=0) and another channel's request: the other channel can win the next cycle, not the same cycle.

## Structure
- Package `mem_arb_pkg`:
  - enum `arb_mode_e` {`ARB_FIXED`, `ARB_RR`};
  - constant `MAX_CH`=8;
  - function `ch_id_w(n)` = max(1, $clog2(n)).
- Sub-module `arb_rr_picker`: combinational one-hot find-first from a start index with wrap, parametrised by `NUM_CH`. Fixed mode drives start=0.
- The top level holds `ptr`, the lock state, the tag pipeline and the muxes.

## Test plan
1. Reset, round-robin, NUM_CH=2, RD_LAT=1. Ch0 and ch1 request reads every cycle. Required: grants alternate 0,1,0,1; each `rvalid` arrives 1 cycle after its grant with matching `rdata`.
2. Fixed mode, NUM_CH=3, all channels requesting continuously. Required: ch0 is granted every cycle; `stall`=3'b110.
3. RD_LAT=3, ch1 reads 0x100, 0x104, 0x108 back-to-back. Required: `rvalid[1]` high in T+3, T+4, T+5 with the RAM words in order.
4. Lock: ch1 reads with `lock`=1, then writes 0xDEADBEEF with `lock`=0; ch0 requests throughout. Required: ch0 stalls for the whole sequence and is granted in the cycle after the write; `ram_we`=4'hF during the write.
5. `rst` pulsed low one cycle after a read is granted, RD_LAT=2. Required: no `rvalid` issued; `ptr`=0; the next requester is granted normally.
6. NUM_CH=4, round-robin, `ptr`=3, only ch1 and ch3 requesting. Required: ch3 is granted, then ch1, then ch3; the pointer wraps correctly.
